fx_add_sub_pipe: RTL

FX_ADD_SUB_PIPE -- requirements
Module: fx_add_sub_pipe

---
 rtl/fx_add_sub_pipe_pkg.sv | 61 ++++++
 rtl/fx_add_sub_pipe_if.sv | 29 ++
 rtl/fx_requant.sv | 48 ++++
 rtl/fx_add_sub_pipe.sv | 106 ++++++++++
 4 files changed

// File: rtl/fx_add_sub_pipe_pkg.sv
// Shared constants and width helpers for the fixed-point add/sub pipeline.
package fx_add_sub_pkg;

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } round_mode_e;

    typedef enum logic {
        OVF_WRAP = 1'b0,
        OVF_SAT  = 1'b1
    } ovf_mode_e;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 16;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Fractional bits once both operands share a binary point.
    function automatic int aligned_frac(input int frac_1, input int frac_2);
        return imax(frac_1, frac_2);
    endfunction

    // Common operand width: widest integer part plus the aligned fraction.
    function automatic int aligned_w(input int w_1, input int frac_1,
                                     input int w_2, input int frac_2);
        return imax(w_1 - frac_1, w_2 - frac_2) + aligned_frac(frac_1, frac_2);
    endfunction

    // Sum/difference width: one guard bit above the aligned width.
    function automatic int internal_w(input int w_1, input int frac_1,
                                      input int w_2, input int frac_2);
        return aligned_w(w_1, frac_1, w_2, frac_2) + 1;
    endfunction

    // Requantisation width: room for the rounding carry, LSB padding and a sign
    // bit above the output range so the range compare is exact.
    function automatic int requant_w(input int in_w, input int in_frac,
                                     input int out_w, input int out_frac);
        return imax(in_w + 1 + imax(out_frac - in_frac, 0), out_w) + 1;
    endfunction

    function automatic longint out_max(input int out_w);
        return (longint'(1) <<< (out_w - 1)) - longint'(1);
    endfunction

    function automatic longint out_min(input int out_w);
        return -(longint'(1) <<< (out_w - 1));
    endfunction

    // Half of the output LSB expressed in input LSBs; zero when no bits drop.
    function automatic longint half_lsb(input int drop);
        if (drop > 0) begin
            return longint'(1) <<< (drop - 1);
        end
        return longint'(0);
    endfunction

endpackage

// File: rtl/fx_add_sub_pipe_if.sv
// Sample/result bus of the fixed-point add/sub pipeline.
interface fx_add_sub_pipe_if #(
    parameter int IN1_W     = 13,
    parameter int IN2_W     = 13,
    parameter int OUT_W     = 12,
    parameter int OVF_CNT_W = 8
);
    logic                    i_valid;
    logic signed [IN1_W-1:0] i_data_1;
    logic signed [IN2_W-1:0] i_data_2;
    logic                    i_sub;
    logic                    i_round;
    logic                    i_sat;
    logic                    i_ovf_clr;
    logic                    o_valid;
    logic signed [OUT_W-1:0] o_data;
    logic                    o_ovf;
    logic [OVF_CNT_W-1:0]    o_ovf_cnt;

    modport master (
        output i_valid, i_data_1, i_data_2, i_sub, i_round, i_sat, i_ovf_clr,
        input  o_valid, o_data, o_ovf, o_ovf_cnt
    );

    modport slave (
        input  i_valid, i_data_1, i_data_2, i_sub, i_round, i_sat, i_ovf_clr,
        output o_valid, o_data, o_ovf, o_ovf_cnt
    );
endinterface

// File: rtl/fx_requant.sv
// Combinational requantisation: round/truncate, range check, saturate or wrap.
module fx_requant
    import fx_add_sub_pkg::*;
#(
    parameter int IN_W     = 15,
    parameter int IN_FRAC  = 10,
    parameter int OUT_W    = 12,
    parameter int OUT_FRAC = 9
) (
    input  logic signed [IN_W-1:0]  din,
    input  logic                    round,
    input  logic                    sat,
    output logic signed [OUT_W-1:0] dout,
    output logic                    ovf
);
    localparam int RW   = requant_w(IN_W, IN_FRAC, OUT_W, OUT_FRAC);
    localparam int PAD  = imax(OUT_FRAC - IN_FRAC, 0);
    localparam int DROP = imax(IN_FRAC - OUT_FRAC, 0);

    localparam logic signed [RW-1:0] HALF  = RW'(half_lsb(DROP));
    localparam logic signed [RW-1:0] MAX_C = RW'(out_max(OUT_W));
    localparam logic signed [RW-1:0] MIN_C = RW'(out_min(OUT_W));

    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] inc;
    logic signed [RW-1:0] scaled;
    logic                 hi;
    logic                 lo;

    // Scale to the output binary point, then clamp or wrap out-of-range values.
    always_comb begin
        ext = {{(RW-IN_W){din[IN_W-1]}}, din};
        inc = '0;
        if (round_mode_e'(round) == RND_HALF_UP) begin
            inc = HALF;
        end
        // Only one of DROP/PAD is non-zero, so a single expression covers both.
        scaled = ((ext + inc) >>> DROP) <<< PAD;
        hi     = scaled > MAX_C;
        lo     = scaled < MIN_C;
        ovf    = hi | lo;
        dout   = scaled[OUT_W-1:0];
        if (ovf && (ovf_mode_e'(sat) == OVF_SAT)) begin
            dout = hi ? MAX_C[OUT_W-1:0] : MIN_C[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/fx_add_sub_pipe.sv
// Pipelined signed fixed-point adder/subtractor with requantisation,
// overflow flagging and a saturating overflow counter.
module fx_add_sub_pipe
    import fx_add_sub_pkg::*;
#(
    parameter int IN1_W     = 13,
    parameter int IN1_FRAC  = 10,
    parameter int IN2_W     = 13,
    parameter int IN2_FRAC  = 10,
    parameter int OUT_W     = 12,
    parameter int OUT_FRAC  = 9,
    parameter int LATENCY   = 2,
    parameter int OVF_CNT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    fx_add_sub_pipe_if.slave  bus
);
    localparam int F  = aligned_frac(IN1_FRAC, IN2_FRAC);
    localparam int SW = internal_w(IN1_W, IN1_FRAC, IN2_W, IN2_FRAC);

    if ((LATENCY < LATENCY_MIN) || (LATENCY > LATENCY_MAX)) begin : g_latency_check
        $error("fx_add_sub_pipe: LATENCY must lie in 1..16");
    end

    logic signed [SW-1:0]    op_1;
    logic signed [SW-1:0]    op_2;
    logic signed [SW-1:0]    arith;
    logic signed [OUT_W-1:0] rq_data;
    logic                    rq_ovf;

    // Align both operands to the common binary point and form the exact result.
    always_comb begin
        op_1  = {{(SW-IN1_W){bus.i_data_1[IN1_W-1]}}, bus.i_data_1} << (F - IN1_FRAC);
        op_2  = {{(SW-IN2_W){bus.i_data_2[IN2_W-1]}}, bus.i_data_2} << (F - IN2_FRAC);
        arith = bus.i_sub ? (op_1 - op_2) : (op_1 + op_2);
    end

    fx_requant #(
        .IN_W     (SW),
        .IN_FRAC  (F),
        .OUT_W    (OUT_W),
        .OUT_FRAC (OUT_FRAC)
    ) u_requant (
        .din  (arith),
        .round(bus.i_round),
        .sat  (bus.i_sat),
        .dout (rq_data),
        .ovf  (rq_ovf)
    );

    // Element s is the input of stage s; element LATENCY is the pipeline output.
    logic                    vld_c  [LATENCY+1];
    logic                    ovf_c  [LATENCY+1];
    logic signed [OUT_W-1:0] data_c [LATENCY+1];
    logic                    vld_q  [LATENCY];
    logic                    ovf_q  [LATENCY];
    logic signed [OUT_W-1:0] data_q [LATENCY];

    assign vld_c[0]  = bus.i_valid;
    assign ovf_c[0]  = rq_ovf;
    assign data_c[0] = rq_data;

    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        // Valid always advances; payload moves only with a valid sample.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                vld_q[s]  <= 1'b0;
                ovf_q[s]  <= 1'b0;
                data_q[s] <= '0;
            end else begin
                vld_q[s] <= vld_c[s];
                if (vld_c[s]) begin
                    ovf_q[s]  <= ovf_c[s];
                    data_q[s] <= data_c[s];
                end
            end
        end

        assign vld_c[s+1]  = vld_q[s];
        assign ovf_c[s+1]  = ovf_q[s];
        assign data_c[s+1] = data_q[s];
    end

    logic [OVF_CNT_W-1:0] cnt_q;
    logic                 cnt_inc;

    assign cnt_inc = vld_c[LATENCY] & ovf_c[LATENCY];

    // Saturating overflow counter; a clear that meets an increment lands on 1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (bus.i_ovf_clr) begin
            cnt_q <= cnt_inc ? OVF_CNT_W'(1) : '0;
        end else if (cnt_inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + OVF_CNT_W'(1);
        end
    end

    assign bus.o_valid   = vld_c[LATENCY];
    assign bus.o_data    = data_c[LATENCY];
    assign bus.o_ovf     = ovf_c[LATENCY];
    assign bus.o_ovf_cnt = cnt_q;

endmodule
